plot_arbiter: RTL and testbench

- Shares the single VGA framebuffer write port (x, y, color_draw, plot) between up to four independent draw engines, e.g. the player sprite drawer, the obstacle drawer and the screen-clear engine.
- Grants the port on a round-robin basis. The owner keeps the port until it drops its request or hits a hold-time limit.
- The owner's pixels are registered through to the adapter one per cycle.
- Sits between the per-object controller/datapath pairs and the VGA adapter.

---
 rtl/plot_arbiter.sv | 175 +++++++++++++++++
 tb/tb_plot_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// Round-robin arbiter that shares the VGA framebuffer write port between up to four draw engines.
// The owner keeps the port until it drops req or runs for MAX_HOLD cycles. Its pixels are registered to the adapter.
module plot_arbiter #(
  parameter int N_REQ    = 2,
  parameter int MAX_HOLD = 19200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   pix_valid,
  input  logic [N_REQ*8-1:0] pix_x,
  input  logic [N_REQ*8-1:0] pix_y,
  input  logic [N_REQ*3-1:0] pix_color,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   pix_ready,
  output logic [7:0]         x,
  output logic [7:0]         y,
  output logic [2:0]         color_draw,
  output logic               plot,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               plot_q, plot_d;
  logic [7:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [2:0]         color_q, color_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;

  logic               own_req;
  logic               own_valid;
  logic [7:0]         own_x;
  logic [7:0]         own_y;
  logic [2:0]         own_color;
  logic [1:0]         next_ptr;
  logic               found;
  logic [N_REQ-1:0]   sel_grant;
  logic [1:0]         sel_idx;
  logic               hold_limit;

  // Owner's request and pixel fields, using constant indices so that out-of-range owners cannot be selected.
  always_comb begin
    own_req   = 1'b0;
    own_valid = 1'b0;
    own_x     = '0;
    own_y     = '0;
    own_color = '0;
    next_ptr  = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        own_req   = req[i];
        own_valid = pix_valid[i];
        own_x     = pix_x[8*i +: 8];
        own_y     = pix_y[8*i +: 8];
        own_color = pix_color[3*i +: 3];
        next_ptr  = 2'((i + 1) % N_REQ);
      end
    end
  end

  // Scan upward from rr_ptr with wrap-around, and pick the first active requester.
  always_comb begin
    found     = 1'b0;
    sel_grant = '0;
    sel_idx   = 2'd0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (j == (int'(rr_ptr_q) + k) % N_REQ)) begin
          found        = 1'b1;
          sel_grant[j] = 1'b1;
          sel_idx      = 2'(j);
        end
      end
    end
  end

  assign hold_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    plot_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    color_d   = color_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          grant_d = sel_grant;
          owner_d = sel_idx;
          hold_d  = '0;
        end
      end
      OWN: begin
        hold_d = hold_q + HOLD_W'(1);
        // pix_ready is high for the whole OWN state, including the release cycle.
        if (own_valid) begin
          plot_d  = 1'b1;
          x_d     = own_x;
          y_d     = own_y;
          color_d = own_color;
        end
        if (!own_req || hold_limit) begin
          state_d   = GAP;
          grant_d   = '0;
          rr_ptr_d  = next_ptr;
          timeout_d = own_req && hold_limit;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
      owner_q   <= 2'd0;
      rr_ptr_q  <= 2'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      color_q   <= color_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant      = grant_q;
  assign pix_ready  = grant_q;
  assign x          = x_q;
  assign y          = y_q;
  assign color_draw = color_q;
  assign plot       = plot_q;
  assign owner      = owner_q;
  assign busy       = (state_q == OWN);
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter with two requesters and a short hold limit.
// Each test task drives its stimulus and checks against expected values worked out by hand.
module tb_plot_arbiter;

  localparam int N  = 2;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  pix_valid;
  logic [N*8-1:0] pix_x;
  logic [N*8-1:0] pix_y;
  logic [N*3-1:0] pix_color;
  logic [N-1:0]  grant;
  logic [N-1:0]  pix_ready;
  logic [7:0]    x;
  logic [7:0]    y;
  logic [2:0]    color_draw;
  logic          plot;
  logic [1:0]    owner;
  logic          busy;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  logic [1:0] alt_exp [10] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};

  plot_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .grant      (grant),
    .pix_ready  (pix_ready),
    .x          (x),
    .y          (y),
    .color_draw (color_draw),
    .plot       (plot),
    .owner      (owner),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    reset     = 1'b1;
    req       = '0;
    pix_valid = '0;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task test_reset;
    do_reset;
    checks++;
    if ({grant, pix_ready, plot, x, y, color_draw, owner, busy, timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: grant=%b plot=%b x=%0d y=%0d color=%b owner=%0d busy=%b timeout=%b, all must be 0",
               grant, plot, x, y, color_draw, owner, busy, timeout);
    end
  endtask

  task test_single_pixel;
    do_reset;
    req = 2'b01;
    pix_valid = 2'b01;
    pix_x[7:0] = 8'd10;
    pix_y[7:0] = 8'd20;
    pix_color[2:0] = 3'b101;
    tick;
    checks++;
    if ({grant, pix_ready, busy, plot} !== {2'b01, 2'b01, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_grant: grant=%b ready=%b busy=%b plot=%b, need 01 01 1 0", grant, pix_ready, busy, plot);
    end
    tick;
    checks++;
    if ({plot, x, y, color_draw} !== {1'b1, 8'd10, 8'd20, 3'b101}) begin
      errors++;
      $display("[TB] FAIL single_plot: plot=%b x=%0d y=%0d color=%b, need 1 10 20 101", plot, x, y, color_draw);
    end
    req = '0;
    pix_valid = '0;
    tick;
  endtask

  task test_handoff;
    int plots;
    plots = 0;
    do_reset;
    req = 2'b11;
    pix_valid = 2'b01;
    pix_x[7:0] = 8'd1;
    tick;
    checks++;
    if ({grant, owner} !== {2'b01, 2'd0}) begin
      errors++;
      $display("[TB] FAIL handoff_first: grant=%b owner=%0d, need 01 0", grant, owner);
    end
    for (int n = 2; n <= 6; n++) begin
      pix_x[7:0] = 8'(n);
      if (n == 4) req = 2'b10;
      tick;
      if (plot) plots++;
      if (n == 4) begin
        pix_valid = '0;
        checks++;
        if ({plot, x} !== {1'b1, 8'd4}) begin
          errors++;
          $display("[TB] FAIL handoff_release_pixel: plot=%b x=%0d, need 1 4", plot, x);
        end
      end
      if (n == 4 || n == 5) begin
        checks++;
        if (grant !== 2'b00) begin
          errors++;
          $display("[TB] FAIL handoff_gap_%0d: grant=%b, need 00", n, grant);
        end
      end
    end
    checks++;
    if (plots !== 3) begin
      errors++;
      $display("[TB] FAIL handoff_plot_count: got %0d, need 3", plots);
    end
    checks++;
    if ({grant, owner} !== {2'b10, 2'd1}) begin
      errors++;
      $display("[TB] FAIL handoff_second: grant=%b owner=%0d, need 10 1", grant, owner);
    end
  endtask

  task test_back_to_back;
    do_reset;
    req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (grant !== alt_exp[i]) begin
        errors++;
        $display("[TB] FAIL alternate_cycle_%0d: grant=%b, need %b", i, grant, alt_exp[i]);
      end
      req = 2'b11 & ~alt_exp[i];
    end
  endtask

  task test_timeout;
    int g0;
    int pl;
    int to;
    g0 = 0;
    pl = 0;
    to = 0;
    do_reset;
    req = 2'b11;
    pix_valid = 2'b01;
    for (int n = 1; n <= 7; n++) begin
      tick;
      if (grant == 2'b01) g0++;
      if (plot) pl++;
      if (timeout) to++;
      if (n == 5) begin
        checks++;
        if ({timeout, grant} !== {1'b1, 2'b00}) begin
          errors++;
          $display("[TB] FAIL timeout_pulse: timeout=%b grant=%b, need 1 00", timeout, grant);
        end
      end
    end
    checks++;
    if (g0 !== MH) begin
      errors++;
      $display("[TB] FAIL timeout_grant_cycles: got %0d, need %0d", g0, MH);
    end
    checks++;
    if (pl !== MH) begin
      errors++;
      $display("[TB] FAIL timeout_plot_count: got %0d, need %0d", pl, MH);
    end
    checks++;
    if (to !== 1) begin
      errors++;
      $display("[TB] FAIL timeout_pulse_count: got %0d, need 1", to);
    end
    checks++;
    if ({grant, owner} !== {2'b10, 2'd1}) begin
      errors++;
      $display("[TB] FAIL timeout_next_owner: grant=%b owner=%0d, need 10 1", grant, owner);
    end
  endtask

  task test_isolation;
    do_reset;
    req = 2'b10;
    pix_valid = 2'b11;
    pix_x[7:0] = 8'd7;
    pix_y[7:0] = 8'd9;
    pix_color[2:0] = 3'b111;
    tick;
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("[TB] FAIL isolation_grant: grant=%b, need 10", grant);
    end
    for (int n = 2; n <= 4; n++) begin
      req[0] = ~req[0];
      pix_x[15:8] = 8'(48 + n);
      pix_y[15:8] = 8'(58 + n);
      pix_color[5:3] = 3'b010;
      if (n == 4) req[1] = 1'b0;
      tick;
      checks++;
      if ({plot, x, y, color_draw, grant} !== {1'b1, 8'(48 + n), 8'(58 + n), 3'b010, (n < 4) ? 2'b10 : 2'b00}) begin
        errors++;
        $display("[TB] FAIL isolation_pixel_%0d: plot=%b x=%0d y=%0d color=%b grant=%b, need 1 %0d %0d 010 %b",
                 n, plot, x, y, color_draw, grant, 48 + n, 58 + n, (n < 4) ? 2'b10 : 2'b00);
      end
    end
    req = '0;
    pix_valid = '0;
    tick;
  endtask

  task test_reset_midburst;
    do_reset;
    req = 2'b10;
    pix_valid = 2'b10;
    pix_x[15:8] = 8'd33;
    pix_y[15:8] = 8'd44;
    pix_color[5:3] = 3'b110;
    tick;
    tick;
    checks++;
    if ({plot, x, grant} !== {1'b1, 8'd33, 2'b10}) begin
      errors++;
      $display("[TB] FAIL midburst_setup: plot=%b x=%0d grant=%b, need 1 33 10", plot, x, grant);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({grant, plot, x, y, color_draw, owner} !== '0) begin
      errors++;
      $display("[TB] FAIL midburst_async_clear: grant=%b plot=%b x=%0d y=%0d color=%b owner=%0d, need all 0",
               grant, plot, x, y, color_draw, owner);
    end
    #1;
    reset = 1'b0;
    tick;
    checks++;
    if ({grant, owner, plot} !== {2'b10, 2'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midburst_regrant: grant=%b owner=%0d plot=%b, need 10 1 0", grant, owner, plot);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req = '0;
    pix_valid = '0;
    pix_x = '0;
    pix_y = '0;
    pix_color = '0;
    test_reset;
    test_single_pixel;
    test_handoff;
    test_back_to_back;
    test_timeout;
    test_isolation;
    test_reset_midburst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
